// File: rtl/testing_cpu_mul_pipe.sv
// testing_cpu_mul_pipe
//   Three-stage pipelined integer multiplier for the testing CPU M-stage.
//   S1 latches operands/op/tag, S2 latches the 16x16 unsigned partial-product
//   array plus the sign-correction sum, S3 latches the reduced product half.
//   The whole pipeline stalls when a result is presented but not taken.
//
//   Build option MUL_PIPE_HIGH_EN:
//     defined   - MUL, MULXSS, MULXSU, MULXUU supported.
//     undefined - only the low-half partial products are built, in_op is
//                 ignored and every operation behaves as MUL.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   operation handshake (in_ready = not stalled)
//   in_op               00 MUL, 01 MULXSS, 10 MULXSU, 11 MULXUU
//   in_a, in_b, in_tag  operands and sideband tag
//   flush               drop every in-flight operation at the next edge
//   out_valid/out_ready result handshake
//   out_result, out_tag selected product half and its tag
//   occupancy           number of valid pipeline stages (0..3)
module testing_cpu_mul_pipe #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [TAG_W-1:0]  out_tag,
  output logic [1:0]        occupancy
);

  localparam int unsigned N    = DATA_W / 16;
  localparam int unsigned PP_W = 32;
`ifdef MUL_PIPE_HIGH_EN
  localparam bit          HIGH_EN = 1'b1;
  localparam int unsigned N_PP    = N * N;
  localparam int unsigned ACC_W   = 2 * DATA_W;
`else
  localparam bit          HIGH_EN = 1'b0;
  // Lower triangle only: partial products landing below bit DATA_W.
  localparam int unsigned N_PP    = (N * (N + 1)) / 2;
  localparam int unsigned ACC_W   = DATA_W;
`endif

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULXSS = 2'b01,
    OP_MULXSU = 2'b10,
    OP_MULXUU = 2'b11
  } op_e;

  logic advance;
  logic s1_valid, s2_valid, s3_valid;

  logic [DATA_W-1:0]    s1_a, s1_b;
  logic [TAG_W-1:0]     s1_tag;
  logic [N_PP*PP_W-1:0] pp_next, s2_pp;
  logic [TAG_W-1:0]     s2_tag;
  logic [ACC_W-1:0]     acc;
  logic [DATA_W-1:0]    res_next, s3_result;
  logic [TAG_W-1:0]     s3_tag;

`ifdef MUL_PIPE_HIGH_EN
  op_e               s1_op, s2_op;
  logic              sa, sb;
  logic [DATA_W:0]   cor_next, s2_cor;
`else
  logic unused_op;
  assign unused_op = ^in_op;
`endif

  // A presented-but-untaken result freezes every stage, bubbles included.
  assign advance    = ~(s3_valid & ~out_ready);
  assign in_ready   = advance;
  assign out_valid  = s3_valid;
  assign out_result = s3_result;
  assign out_tag    = s3_tag;
  assign occupancy  = {1'b0, s1_valid} + {1'b0, s2_valid} + {1'b0, s3_valid};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
    end else if (advance) begin
      s1_valid <= in_valid;
      s2_valid <= s1_valid;
      s3_valid <= s2_valid;
    end
  end

  // Partial products: 16-bit slices of A and B multiplied as unsigned.
  always_comb begin
    int unsigned k;
    pp_next = '0;
    k = 0;
    for (int unsigned i = 0; i < N; i++) begin
      for (int unsigned j = 0; j < N; j++) begin
        if (HIGH_EN || ((i + j) < N)) begin
          pp_next[k*PP_W +: PP_W] = 32'(s1_a[i*16 +: 16]) * 32'(s1_b[j*16 +: 16]);
          k++;
        end
      end
    end
  end

`ifdef MUL_PIPE_HIGH_EN
  // Signed operand x = x_u - x[msb]*2^W, so the signed product equals the
  // unsigned one minus (sa*b + sb*a) << W (the sa*sb term falls off the top).
  always_comb begin
    sa = ((s1_op == OP_MULXSS) || (s1_op == OP_MULXSU)) && s1_a[DATA_W-1];
    sb = (s1_op == OP_MULXSS) && s1_b[DATA_W-1];
    cor_next = (sa ? {1'b0, s1_b} : '0) + (sb ? {1'b0, s1_a} : '0);
  end
`endif

  always_comb begin
    int unsigned k;
    acc = '0;
    k = 0;
    for (int unsigned i = 0; i < N; i++) begin
      for (int unsigned j = 0; j < N; j++) begin
        if (HIGH_EN || ((i + j) < N)) begin
          acc = acc + (ACC_W'(s2_pp[k*PP_W +: PP_W]) << (16 * (i + j)));
          k++;
        end
      end
    end
`ifdef MUL_PIPE_HIGH_EN
    acc = acc - (ACC_W'(s2_cor) << DATA_W);
    res_next = (s2_op == OP_MUL) ? acc[DATA_W-1:0] : acc[ACC_W-1:DATA_W];
`else
    res_next = acc;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_a      <= '0;
      s1_b      <= '0;
      s1_tag    <= '0;
      s2_pp     <= '0;
      s2_tag    <= '0;
      s3_result <= '0;
      s3_tag    <= '0;
`ifdef MUL_PIPE_HIGH_EN
      s1_op     <= OP_MUL;
      s2_op     <= OP_MUL;
      s2_cor    <= '0;
`endif
    end else begin
      if (in_valid && advance && !flush) begin
        s1_a   <= in_a;
        s1_b   <= in_b;
        s1_tag <= in_tag;
`ifdef MUL_PIPE_HIGH_EN
        s1_op  <= op_e'(in_op);
`endif
      end
      if (s1_valid && advance) begin
        s2_pp  <= pp_next;
        s2_tag <= s1_tag;
`ifdef MUL_PIPE_HIGH_EN
        s2_op  <= s1_op;
        s2_cor <= cor_next;
`endif
      end
      if (s2_valid && advance) begin
        s3_result <= res_next;
        s3_tag    <= s2_tag;
      end
    end
  end

endmodule

// File: tb/tb_testing_cpu_mul_pipe.sv
// Testbench for testing_cpu_mul_pipe (DATA_W = 32, TAG_W = 5).
// Reference model: a queue of outstanding operations with the expected
// product half, tag and number of pipeline advances since acceptance.
module tb_testing_cpu_mul_pipe;

`ifdef MUL_PIPE_HIGH_EN
  localparam bit HIGH_EN = 1'b1;
`else
  localparam bit HIGH_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_a, in_b;
  logic [4:0]  in_tag;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_tag;
  logic [1:0]  occupancy;

  logic [31:0] drv_exp;
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
    int unsigned age;
  } ent_t;
  ent_t q[$];

  testing_cpu_mul_pipe #(.DATA_W(32), .TAG_W(5)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, p;
    bit a_signed, b_signed;
    a_signed = HIGH_EN && (op == 2'b01 || op == 2'b10);
    b_signed = HIGH_EN && (op == 2'b01);
    ea = a_signed ? {{32{a[31]}}, a} : {32'b0, a};
    eb = b_signed ? {{32{b[31]}}, b} : {32'b0, b};
    p  = ea * eb;
    if (HIGH_EN && op != 2'b00) return p[63:32];
    return p[31:0];
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Scoreboard: compare current outputs, then apply the upcoming clock edge.
  always @(negedge clk) begin
    bit exp_ov, stall;
    if (reset) begin
      q.delete();
    end else begin
      exp_ov = (q.size() > 0) && (q[0].age >= 3);
      check("out_valid", 64'(out_valid), 64'(exp_ov));
      check("in_ready", 64'(in_ready), 64'(!(exp_ov && !out_ready)));
      check("occupancy", 64'(occupancy), 64'(q.size()));
      if (exp_ov) begin
        check("out_result", 64'(out_result), 64'(q[0].res));
        check("out_tag", 64'(out_tag), 64'(q[0].tag));
      end
      stall = exp_ov && !out_ready;
      if (exp_ov && out_ready) void'(q.pop_front());
      if (flush) begin
        q.delete();
      end else if (!stall) begin
        foreach (q[i]) q[i].age = q[i].age + 1;
        if (in_valid) q.push_back('{res: drv_exp, tag: in_tag, age: 1});
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] tag, input logic [31:0] exp);
    int unsigned n;
    bit done;
    n = 0;
    done = 1'b0;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag; drv_exp = exp;
    while (!done) begin
      @(negedge clk);
      done = in_ready;
      n++;
      @(posedge clk); #1;
      if (!done && n >= 100) begin
        check("send_timeout", 64'(in_ready), 64'd1);
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int unsigned n;
    n = 0;
    while (q.size() != 0 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain", 64'(q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned lat;
    reset = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; in_tag = '0;
    flush = 1'b0; out_ready = 1'b1; drv_exp = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_occupancy", 64'(occupancy), 64'd0);
    check("rst_out_result", 64'(out_result), 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Latency: first result exactly three cycles after the accept cycle.
    send(2'b00, 32'h0001_0000, 32'h0001_0000, 5'd3, 32'h0000_0000);
    lat = 0;
    for (int unsigned k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    check("latency", 64'(lat), 64'd3);
    check("lat_result", 64'(out_result), 64'h0);
    check("lat_tag", 64'(out_tag), 64'd3);
    @(posedge clk); #1;
    wait_drain();

    // All-ones operands through every op.
    send(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, HIGH_EN ? 32'hFFFF_FFFE : 32'h0000_0001);
    send(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, HIGH_EN ? 32'h0000_0000 : 32'h0000_0001);
    send(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, HIGH_EN ? 32'hFFFF_FFFF : 32'h0000_0001);
    send(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 32'h0000_0001);
    wait_drain();

    // Backpressure: out_ready held low for 5 cycles after the first result.
    out_ready = 1'b0;
    fork
      begin
        send(2'b00, 32'd2, 32'd3, 5'd10, 32'd6);
        send(2'b00, 32'd4, 32'd5, 5'd11, 32'd20);
        send(2'b00, 32'd6, 32'd7, 5'd12, 32'd42);
        send(2'b00, 32'd8, 32'd9, 5'd13, 32'd72);
      end
      begin
        for (int unsigned k = 0; k < 20 && !out_valid; k++) @(negedge clk);
        repeat (5) @(negedge clk);
        check("bp_stalled_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    wait_drain();

    // Flush with three in flight and a fourth offered in the flush cycle.
    out_ready = 1'b0;
    send(2'b00, 32'd11, 32'd12, 5'd20, 32'd132);
    send(2'b00, 32'd13, 32'd14, 5'd21, 32'd182);
    send(2'b00, 32'd15, 32'd16, 5'd22, 32'd240);
    in_valid = 1'b1; in_a = 32'd17; in_b = 32'd18; in_tag = 5'd23; drv_exp = 32'd306;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_occupancy", 64'(occupancy), 64'd0);
    out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;

    // Asynchronous reset with a full pipeline.
    out_ready = 1'b0;
    send(2'b00, 32'd3, 32'd3, 5'd1, 32'd9);
    send(2'b00, 32'd4, 32'd4, 5'd2, 32'd16);
    send(2'b00, 32'd5, 32'd5, 5'd3, 32'd25);
    check("pre_rst_occupancy", 64'(occupancy), 64'd3);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_out_valid", 64'(out_valid), 64'd0);
    check("async_rst_occupancy", 64'(occupancy), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    send(2'b11, 32'h8000_0000, 32'd2, 5'd9, HIGH_EN ? 32'h0000_0001 : 32'h0000_0000);
    wait_drain();

    // Randomized traffic with random backpressure and occasional flushes.
    for (int unsigned c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_op     = 2'($urandom_range(0, 3));
      in_a      = pick();
      in_b      = pick();
      in_tag    = 5'($urandom_range(0, 31));
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      drv_exp   = model(in_op, in_a, in_b);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
